// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: hazard detection and EX operand forwarding for the ARM pipe.
// Optional macro HAZARD_PERF_CNT_EN adds hz_stall_cnt_out / mem_stall_cnt_out.
// Ports: clk, rst (sync, active-high); forward_en_in; id_* (ID instruction);
//   flush_in, mem_stall_in; stall_out, sel_src1_out, sel_src2_out, inflight_out.
module pipe_hazard_scoreboard #(
    parameter int REG_W            = 4,
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = $clog2(NUM_STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en_in,
    input  logic             id_valid_in,
    input  logic [REG_W-1:0] id_src1_in,
    input  logic [REG_W-1:0] id_src2_in,
    input  logic             id_two_src_in,
    input  logic             id_wb_en_in,
    input  logic             id_mem_r_en_in,
    input  logic [REG_W-1:0] id_dest_in,
    input  logic             flush_in,
    input  logic             mem_stall_in,
    output logic             stall_out,
    output logic [SEL_W-1:0] sel_src1_out,
    output logic [SEL_W-1:0] sel_src2_out,
    output logic [SEL_W:0]   inflight_out
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      hz_stall_cnt_out,
    output logic [31:0]      mem_stall_cnt_out
`endif
);

    logic [NUM_STAGES-1:0] v_q, wb_q, ld_q, v_nxt;
    logic [REG_W-1:0]      dest_q [NUM_STAGES];
    logic [REG_W-1:0]      src1_q [NUM_STAGES];
    logic [REG_W-1:0]      src2_q [NUM_STAGES];
    logic [SEL_W:0]        inflight_q, inflight_nxt;
    logic                  hazard, take0;
    logic [SEL_W-1:0]      sel1, sel2;

    // Hazard only looks at EX..WB-1; WB is covered by write-before-read.
    // In forwarding mode only loads too young to forward cause a stall.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NUM_STAGES - 1; k++) begin
            if (id_valid_in && v_q[k] && wb_q[k] &&
                (!forward_en_in || (ld_q[k] && (k + 2 <= LOAD_READY_STAGE))) &&
                ((dest_q[k] == id_src1_in) ||
                 (id_two_src_in && (dest_q[k] == id_src2_in))))
                hazard = 1'b1;
        end
    end

    // Walk oldest to youngest so the nearest matching stage wins.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            if (v_q[k] && wb_q[k] && !(ld_q[k] && (k < LOAD_READY_STAGE))) begin
                if (dest_q[k] == src1_q[0]) sel1 = SEL_W'(k);
                if (dest_q[k] == src2_q[0]) sel2 = SEL_W'(k);
            end
        end
        if (!(v_q[0] && forward_en_in)) begin
            sel1 = '0;
            sel2 = '0;
        end
    end

    assign take0 = id_valid_in & ~hazard & ~flush_in;

    always_comb begin
        v_nxt        = {v_q[NUM_STAGES-2:0], take0};
        inflight_nxt = '0;
        for (int k = 0; k < NUM_STAGES; k++)
            inflight_nxt = inflight_nxt + {{SEL_W{1'b0}}, v_nxt[k]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q        <= '0;
            wb_q       <= '0;
            ld_q       <= '0;
            inflight_q <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                dest_q[k] <= '0;
                src1_q[k] <= '0;
                src2_q[k] <= '0;
            end
        end else if (!mem_stall_in) begin
            v_q        <= v_nxt;
            wb_q       <= {wb_q[NUM_STAGES-2:0], id_wb_en_in};
            ld_q       <= {ld_q[NUM_STAGES-2:0], id_mem_r_en_in};
            inflight_q <= inflight_nxt;
            for (int k = NUM_STAGES - 1; k > 0; k--) begin
                dest_q[k] <= dest_q[k-1];
                src1_q[k] <= src1_q[k-1];
                src2_q[k] <= src2_q[k-1];
            end
            dest_q[0] <= id_dest_in;
            src1_q[0] <= id_src1_in;
            src2_q[0] <= id_src2_in;
        end
    end

    assign stall_out    = ~rst & (mem_stall_in | (hazard & ~flush_in));
    assign sel_src1_out = rst ? '0 : sel1;
    assign sel_src2_out = rst ? '0 : sel2;
    assign inflight_out = rst ? '0 : inflight_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] hz_cnt_q, mem_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hz_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            if (hazard && !flush_in && !mem_stall_in && (hz_cnt_q != 32'hFFFF_FFFF))
                hz_cnt_q <= hz_cnt_q + 32'd1;
            if (mem_stall_in && (mem_cnt_q != 32'hFFFF_FFFF))
                mem_cnt_q <= mem_cnt_q + 32'd1;
        end
    end

    assign hz_stall_cnt_out  = rst ? '0 : hz_cnt_q;
    assign mem_stall_cnt_out = rst ? '0 : mem_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: directed bench for pipe_hazard_scoreboard.
// Checks a 3-stage default instance and a 5-stage instance sharing inputs.
module tb_pipe_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst, fwd, id_v, two, wb, ld, flush, mstall;
    logic [3:0] s1, s2, dst;

    logic       st0, st1;
    logic [1:0] a1_0, a2_0;
    logic [2:0] inf0;
    logic [2:0] a1_1, a2_1;
    logic [3:0] inf1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] hz0, mc0, hz1, mc1;
`endif

    always #5 clk = ~clk;

    pipe_hazard_scoreboard u0 (
        .clk(clk), .rst(rst), .forward_en_in(fwd), .id_valid_in(id_v),
        .id_src1_in(s1), .id_src2_in(s2), .id_two_src_in(two),
        .id_wb_en_in(wb), .id_mem_r_en_in(ld), .id_dest_in(dst),
        .flush_in(flush), .mem_stall_in(mstall), .stall_out(st0),
        .sel_src1_out(a1_0), .sel_src2_out(a2_0), .inflight_out(inf0)
`ifdef HAZARD_PERF_CNT_EN
        , .hz_stall_cnt_out(hz0), .mem_stall_cnt_out(mc0)
`endif
    );

    pipe_hazard_scoreboard #(.NUM_STAGES(5), .LOAD_READY_STAGE(3)) u1 (
        .clk(clk), .rst(rst), .forward_en_in(fwd), .id_valid_in(id_v),
        .id_src1_in(s1), .id_src2_in(s2), .id_two_src_in(two),
        .id_wb_en_in(wb), .id_mem_r_en_in(ld), .id_dest_in(dst),
        .flush_in(flush), .mem_stall_in(mstall), .stall_out(st1),
        .sel_src1_out(a1_1), .sel_src2_out(a2_1), .inflight_out(inf1)
`ifdef HAZARD_PERF_CNT_EN
        , .hz_stall_cnt_out(hz1), .mem_stall_cnt_out(mc1)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL queue_empty observed=%0d required=entry", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic set_id(input logic v, input logic [3:0] a, input logic [3:0] b,
                          input logic t, input logic w, input logic l,
                          input logic [3:0] d);
        id_v = v; s1 = a; s2 = b; two = t; wb = w; ld = l; dst = d;
    endtask

    task automatic idle();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step0(input string tag, input int st, input int x1,
                         input int x2, input int inf);
        push({tag, ".stall"}, 32'(st));
        push({tag, ".sel1"}, 32'(x1));
        push({tag, ".sel2"}, 32'(x2));
        push({tag, ".inflight"}, 32'(inf));
        #2;
        chk(32'(st0));
        chk(32'(a1_0));
        chk(32'(a2_0));
        chk(32'(inf0));
        @(negedge clk);
    endtask

    task automatic step1(input string tag, input int st, input int x1,
                         input int x2, input int inf);
        push({tag, ".stall"}, 32'(st));
        push({tag, ".sel1"}, 32'(x1));
        push({tag, ".sel2"}, 32'(x2));
        push({tag, ".inflight"}, 32'(inf));
        #2;
        chk(32'(st1));
        chk(32'(a1_1));
        chk(32'(a2_1));
        chk(32'(inf1));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; mstall = 1'b0; flush = 1'b0;
        idle();
        step0("rst", 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fwd = 1'b1; flush = 1'b0; mstall = 1'b1;
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3);
        @(negedge clk);
        step0("init_rst", 0, 0, 0, 0);

        // Forwarding from ALU results
        rst = 1'b0; mstall = 1'b0;
        set_id(1'b1, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 4'd2);
        step0("add", 0, 0, 0, 0);
        set_id(1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 4'd6);
        step0("sub", 0, 0, 0, 1);
        set_id(1'b1, 4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 4'd7);
        step0("fwd_k1", 0, 1, 0, 2);
        set_id(1'b1, 4'd12, 4'd13, 1'b1, 1'b1, 1'b0, 4'd11);
        step0("fwd_k2", 0, 2, 2, 3);

        // Reset with three valid entries
        rst = 1'b1; mstall = 1'b1;
        step0("mid_rst", 0, 0, 0, 0);
        rst = 1'b0; mstall = 1'b0;
        idle();
        step0("post_rst", 0, 0, 0, 0);

        // Load-use: one stall then forward from entry 2
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3);
        step0("ldr", 0, 0, 0, 0);
        set_id(1'b1, 4'd8, 4'd3, 1'b1, 1'b1, 1'b0, 4'd9);
        step0("ld_use_a", 1, 0, 0, 1);
        step0("ld_use_b", 0, 0, 0, 1);
        idle();
        step0("ld_fwd", 0, 0, 2, 2);
        step0("ld_drain", 0, 0, 0, 1);

        // Stall-only mode
        do_reset();
        fwd = 1'b0;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5);
        step0("so_w", 0, 0, 0, 0);
        set_id(1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 4'd6);
        step0("so_a", 1, 0, 0, 1);
        step0("so_b", 1, 0, 0, 1);
        step0("so_rel", 0, 0, 0, 1);
        idle();
        step0("so_ex", 0, 0, 0, 1);

        // Flush beats hazard, then a whole-pipe memory stall
        do_reset();
        fwd = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3);
        step0("fl_ldr", 0, 0, 0, 0);
        set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4);
        flush = 1'b1;
        step0("fl_hz", 0, 0, 0, 1);
        flush = 1'b0;
        set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd13);
        step0("fl_bub", 0, 0, 0, 1);
        idle();
        mstall = 1'b1; flush = 1'b1;
        for (int i = 0; i < 4; i++)
            step0($sformatf("ms%0d", i), 1, 2, 0, 2);
        mstall = 1'b0; flush = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        push("u0_hz_cnt", 32'd0);
        push("u0_ms_cnt", 32'd4);
        chk(hz0);
        chk(mc0);
`endif
        step0("ms_rel", 0, 2, 0, 2);
        step0("ms_adv", 0, 0, 0, 1);

        // Five-stage pipe with late load data
        do_reset();
        fwd = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7);
        step1("d5_ldr", 0, 0, 0, 0);
        set_id(1'b1, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 4'd8);
        step1("d5_a", 1, 0, 0, 1);
        step1("d5_b", 1, 0, 0, 1);
        step1("d5_rel", 0, 0, 0, 1);
        idle();
        #2;
`ifdef HAZARD_PERF_CNT_EN
        push("u1_hz_cnt", 32'd2);
        push("u1_ms_cnt", 32'd0);
        chk(hz1);
        chk(mc1);
`endif
        push("d5_fwd.sel1", 32'd3);
        push("d5_fwd.stall", 32'd0);
        push("d5_fwd.inflight", 32'd2);
        chk(32'(a1_1));
        chk(32'(st1));
        chk(32'(inf1));

        if (q.size() != 0) begin
            errors++;
            $error("FAIL queue_leftover observed=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding controller for the ARM pipeline; replaces the fixed combinational hazard and forwarding pair.
- Keeps its own shift-register scoreboard of in-flight instructions from EX onward.
- Generates the ID-stage freeze and the EX-stage operand-forward selects.
- Supports configurable post-ID depth, configurable load-data stage, branch flush and a whole-pipe memory stall.

Parameters:
- REG_W, 4, register-address width.
- NUM_STAGES, 3, tracked post-ID stages (entry 0 = EX, entry NUM_STAGES-1 = WB); legal range 2..8.
- LOAD_READY_STAGE, 2, lowest entry index whose load data is forwardable; legal range 1..NUM_STAGES-1.
- SEL_W, $clog2(NUM_STAGES), forward-select width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- forward_en_in  in  1  1 = forwarding mode, 0 = stall-only mode.
- id_valid_in  in  1  ID holds a real instruction.
- id_src1_in  in  REG_W  Rn of the ID instruction.
- id_src2_in  in  REG_W  second source of the ID instruction.
- id_two_src_in  in  1  src2 is read.
- id_wb_en_in  in  1  the ID instruction writes a register.
- id_mem_r_en_in  in  1  the ID instruction is a load.
- id_dest_in  in  REG_W  destination of the ID instruction.
- flush_in  in  1  branch taken; discard the ID instruction.
- mem_stall_in  in  1  memory not ready; freeze the whole pipe.
- stall_out  out  1  freeze PC and the IF/ID register; bubble into ID/EX.
- sel_src1_out  out  SEL_W  forward source for the EX operand 1 (0 = register file, k = entry k).
- sel_src2_out  out  SEL_W  forward source for the EX operand 2.
- inflight_out  out  SEL_W+1  number of valid entries.

Behaviour:
- Entry fields: valid, wb_en, mem_r_en, dest, src1, src2. Reset clears every entry (valid=0), including mid-operation. While rst=1, all outputs are 0.
- Advance when mem_stall_in=0:
  - Entry k+1 takes entry k.
  - Entry 0 takes the ID fields if id_valid_in=1, hazard=0 and flush_in=0; otherwise it takes a bubble (valid=0).
- Hold when mem_stall_in=1: all entries keep their value; flush_in is ignored that cycle (the source holds it).
- Match(k, r): entry k valid & wb_en & dest==r.
- Hazard (combinational, 0-cycle latency):
  - Applies only when id_valid_in=1 and only to entries 0..NUM_STAGES-2. The WB entry is covered by the register file's write-before-read.
  - A source is "used" as follows: src1 always; src2 only if id_two_src_in=1.
  - forward_en_in=0: hazard = any Match(k, used src).
  - forward_en_in=1: hazard = any Match(k, used src) where entry k is a load and k <= LOAD_READY_STAGE-2.
- stall_out = mem_stall_in | (hazard & ~flush_in). Flush beats hazard.
- Forward select:
  - sel_srcN_out = smallest k in 1..NUM_STAGES-1 with Match(k, entry0.srcN), provided entry 0 is valid and forward_en_in=1; else 0.
  - A load entry with k < LOAD_READY_STAGE is never selected.
  - Nearest stage has priority.
- Register 0 gets no special treatment (ARM R0 is real).
- inflight_out = population count of valid entries. It is registered with the entries.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs hz_stall_cnt_out[31:0] and mem_stall_cnt_out[31:0].
  - They increment each cycle that (hazard & ~flush_in & ~mem_stall_in) and mem_stall_in respectively.
  - Both saturate at 32'hFFFFFFFF and are cleared by rst.
- When undefined: no counters and no extra ports. The rest of the behaviour is identical.

Test Plan:
- Reset mid-run with 3 valid entries, rst=1 for one cycle -> inflight_out=0 and both sel outputs 0 the following cycle; stall_out=0.
- forward_en_in=1, ADD R2 (dest 2) then SUB using src1=2 -> no stall; the next cycle sel_src1_out=1; one cycle later, with an unrelated instruction in between, sel_src1_out=2.
- forward_en_in=1, LDR R3 in entry 0, ID src2=3, two_src=1 -> stall_out=1 for exactly 1 cycle; then the consumer enters EX with sel_src2_out=2.
- forward_en_in=0, dest 5 in entry 0, ID src1=5 -> stall_out=1 for 2 cycles and bubbles inserted; released when the writer reaches WB.
- Hazard active plus flush_in=1 -> stall_out=0 and entry 0 becomes a bubble. With mem_stall_in=1 for 4 cycles -> entries unchanged and stall_out=1 throughout.
- NUM_STAGES=5, LOAD_READY_STAGE=3, load dest 7 in entry 0, ID src1=7 -> stall 2 cycles, then sel_src1_out=3. With HAZARD_PERF_CNT_EN defined, hz_stall_cnt_out=2.
